// File: rtl/pong_pkg.sv
// Shared pong definitions: game phases, winner codes, default sizes and screen geometry.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } game_state_e;

  localparam logic [1:0] WINNER_NONE = 2'd0;
  localparam logic [1:0] WINNER_P1   = 2'd1;
  localparam logic [1:0] WINNER_P2   = 2'd2;

  localparam int SCORE_W_DEF   = 4;
  localparam int WIN_SCORE_DEF = 7;

  // Playfield size shared with the paddle and ball blocks
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/frame_timer.sv
// Frame-tick down-counter with load; done is high while the count is zero.
module frame_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               tick,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: idle/serve/play/point/game-over sequencing and scoring.
// Optional pause input enabled by defining PONG_PAUSE_EN.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int SERVE_DELAY = 60,
  parameter int POINT_DELAY = 30,
  parameter int TIMER_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
`ifdef PONG_PAUSE_EN
  input  logic               pause,
`endif
  output logic               ball_rst,
  output logic               ball_run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic [2:0]         game_state
);

  localparam logic [SCORE_W-1:0] WIN_VAL     = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] SERVE_LOAD  = TIMER_W'(SERVE_DELAY);
  localparam logic [TIMER_W-1:0] POINT_LOAD  = TIMER_W'(POINT_DELAY);

  game_state_e        state, state_n;
  logic [SCORE_W-1:0] score1_n, score2_n, inc1, inc2;
  logic [1:0]         winner_n;
  logic               dir_n;
  logic               start_q, start_rise;
  logic               paused, paused_n, pause_rise;
  logic               timer_load, timer_tick, timer_done;
  logic [TIMER_W-1:0] timer_value;

  assign start_rise = start & ~start_q;

`ifdef PONG_PAUSE_EN
  logic pause_q;

  always_ff @(posedge clk) begin
    if (!rst) pause_q <= 1'b0;
    else      pause_q <= pause;
  end

  assign pause_rise = pause & ~pause_q;
`else
  assign pause_rise = 1'b0;
`endif

  frame_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .tick       (timer_tick),
    .done       (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      score1    <= '0;
      score2    <= '0;
      winner    <= WINNER_NONE;
      serve_dir <= 1'b0;
      ball_rst  <= 1'b1;
      ball_run  <= 1'b0;
      start_q   <= 1'b0;
      paused    <= 1'b0;
    end else begin
      state     <= state_n;
      score1    <= score1_n;
      score2    <= score2_n;
      winner    <= winner_n;
      serve_dir <= dir_n;
      ball_rst  <= (state_n != PLAY);
      ball_run  <= (state_n == PLAY) && !paused_n;
      start_q   <= start;
      paused    <= paused_n;
    end
  end

  always_comb begin
    state_n     = state;
    score1_n    = score1;
    score2_n    = score2;
    winner_n    = winner;
    dir_n       = serve_dir;
    paused_n    = paused;
    timer_load  = 1'b0;
    timer_value = SERVE_LOAD;
    timer_tick  = 1'b0;
    inc1        = score1 + 1'b1;
    inc2        = score2 + 1'b1;

    if (pause_rise && (state == SERVE || state == PLAY || state == POINT)) begin
      paused_n = !paused;
    end

    // A paused game freezes the timer, ignores misses and holds its phase
    if (!paused) begin
      case (state)
        IDLE: begin
          if (start_rise) begin
            state_n    = SERVE;
            score1_n   = '0;
            score2_n   = '0;
            winner_n   = WINNER_NONE;
            timer_load = 1'b1;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (timer_done) state_n = PLAY;
            else            timer_tick = 1'b1;
          end
        end
        PLAY: begin
          if (miss_left && miss_right) begin
            state_n     = POINT;
            timer_load  = 1'b1;
            timer_value = POINT_LOAD;
          end else if (miss_left || miss_right) begin
            dir_n = miss_right;
            if (miss_left) score2_n = inc2;
            else           score1_n = inc1;
            if ((miss_left ? inc2 : inc1) == WIN_VAL) begin
              state_n  = GAMEOVER;
              winner_n = miss_left ? WINNER_P2 : WINNER_P1;
            end else begin
              state_n     = POINT;
              timer_load  = 1'b1;
              timer_value = POINT_LOAD;
            end
          end
        end
        POINT: begin
          if (frame_tick) begin
            if (timer_done) begin
              state_n    = SERVE;
              timer_load = 1'b1;
            end else begin
              timer_tick = 1'b1;
            end
          end
        end
        GAMEOVER: begin
          if (start_rise) begin
            state_n    = SERVE;
            score1_n   = '0;
            score2_n   = '0;
            winner_n   = WINNER_NONE;
            dir_n      = 1'b0;
            timer_load = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (state_n == IDLE || state_n == GAMEOVER) paused_n = 1'b0;
  end

  assign game_state = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized bench for pong_game_ctrl against a tick-counting reference model.
module tb_pong_game_ctrl;

  localparam int SCORE_W     = 4;
  localparam int WIN_SCORE   = 3;
  localparam int SERVE_DELAY = 2;
  localparam int POINT_DELAY = 3;
  localparam int TIMER_W     = 8;

  localparam int PH_IDLE = 0, PH_SERVE = 1, PH_PLAY = 2, PH_POINT = 3, PH_OVER = 4;

  logic clk = 1'b0;
  logic rst, frame_tick, start, miss_left, miss_right;
  logic ball_rst, ball_run, serve_dir;
  logic [SCORE_W-1:0] score1, score2;
  logic [1:0] winner;
  logic [2:0] game_state;
`ifdef PONG_PAUSE_EN
  logic pause = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase, scores and number of frame ticks seen in the phase
  int m_phase, m_s1, m_s2, m_win, m_dir, m_ticks;
  logic m_start_prev;
  logic hold_start;

  always #5 clk = ~clk;

  pong_game_ctrl #(
    .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE), .SERVE_DELAY(SERVE_DELAY),
    .POINT_DELAY(POINT_DELAY), .TIMER_W(TIMER_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .miss_left  (miss_left),
    .miss_right (miss_right),
`ifdef PONG_PAUSE_EN
    .pause      (pause),
`endif
    .ball_rst   (ball_rst),
    .ball_run   (ball_run),
    .serve_dir  (serve_dir),
    .score1     (score1),
    .score2     (score2),
    .winner     (winner),
    .game_state (game_state)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_phase = PH_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_ticks = 0;
    m_start_prev = 1'b0;
  endtask

  task automatic modelStep(input logic r, s, ft, ml, mr);
    logic rise;
    if (!r) begin
      modelReset();
      return;
    end
    rise = s && !m_start_prev;
    m_start_prev = s;
    case (m_phase)
      PH_IDLE, PH_OVER: if (rise) begin
        m_phase = PH_SERVE; m_s1 = 0; m_s2 = 0; m_win = 0; m_ticks = 0;
        m_dir = 0;
      end
      PH_SERVE: if (ft) begin
        if (m_ticks == SERVE_DELAY) m_phase = PH_PLAY;
        else m_ticks++;
      end
      PH_POINT: if (ft) begin
        if (m_ticks == POINT_DELAY) begin m_phase = PH_SERVE; m_ticks = 0; end
        else m_ticks++;
      end
      PH_PLAY: begin
        if (ml && !mr) begin m_s2++; m_dir = 0; end
        if (mr && !ml) begin m_s1++; m_dir = 1; end
        if (ml || mr) begin
          m_ticks = 0;
          if (m_s1 == WIN_SCORE) begin m_phase = PH_OVER; m_win = 1; end
          else if (m_s2 == WIN_SCORE) begin m_phase = PH_OVER; m_win = 2; end
          else m_phase = PH_POINT;
        end
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  task automatic checkAll();
    checkOutput("game_state", 8'(game_state), 8'(m_phase));
    checkOutput("score1", 8'(score1), 8'(m_s1));
    checkOutput("score2", 8'(score2), 8'(m_s2));
    checkOutput("winner", 8'(winner), 8'(m_win));
    checkOutput("serve_dir", 8'(serve_dir), 8'(m_dir));
    checkOutput("ball_rst", 8'(ball_rst), 8'(m_phase != PH_PLAY));
    checkOutput("ball_run", 8'(ball_run), 8'(m_phase == PH_PLAY));
  endtask

  // Check the state reached by the previous edge, then drive the next cycle
  task automatic applyStimulus(input logic r, s, ft, ml, mr);
    checkAll();
    rst = r; start = s; frame_tick = ft; miss_left = ml; miss_right = mr;
    modelStep(r, s, ft, ml, mr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, hold_start, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pointThenServe();
    ticks(POINT_DELAY + 1);
    ticks(SERVE_DELAY + 1);
  endtask

  initial begin
    logic r, s, ft, ml, mr;
    rst = 1'b0; start = 1'b0; frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    hold_start = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_start = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(SERVE_DELAY + 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    hold_start = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pointThenServe();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    pointThenServe();
    for (int k = 0; k < WIN_SCORE; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      if (k < WIN_SCORE - 1) pointThenServe();
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(SERVE_DELAY + 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pointThenServe();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pointThenServe();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    s = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 7) == 0) s = ~s;
      ft = ($urandom_range(0, 2) == 0);
      ml = ($urandom_range(0, 9) == 0);
      mr = ($urandom_range(0, 9) == 0);
      applyStimulus(r, s, ft, ml, mr);
    end
    checkAll();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-flow controller for the pong datapath. Sequences the ball engine through idle, serve, play, point and game-over phases, and keeps both players' scores. Consumes per-frame ticks and miss events from the collision detector. Drives ball reset/run enables and serve direction into the ball block.

Parameters:
SCORE_W, 4, width of each score counter
WIN_SCORE, 7, score that ends the game; must be < 2**SCORE_W
SERVE_DELAY, 60, frame ticks spent in SERVE before the ball is released
POINT_DELAY, 30, frame ticks spent in POINT after a miss
TIMER_W, 8, width of frame down-counter; must hold max(SERVE_DELAY, POINT_DELAY)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse, once per video frame
start  in  1  start button, level; internally rising-edge detected
miss_left  in  1  one-cycle pulse: ball passed player1 (left) edge
miss_right  in  1  one-cycle pulse: ball passed player2 (right) edge
ball_rst  out  1  hold ball at centre
ball_run  out  1  ball position update enable
serve_dir  out  1  0 = serve toward left, 1 = toward right
score1  out  SCORE_W  player1 score
score2  out  SCORE_W  player2 score
winner  out  2  0 none, 1 player1, 2 player2
game_state  out  3  encoded current state (debug/display)

Behaviour:
- Clock and reset decided: one clock; reset is synchronous and active-low.
- Reset (rst=0 at posedge, any state, mid-game included): state IDLE, score1=score2=0, winner=0, serve_dir=0, ball_rst=1, ball_run=0, timer=0, start edge register=0.
- All outputs registered; Moore outputs from state: ball_rst=1 in every state except PLAY; ball_run=1 only in PLAY.
- Start edge: start_q registered each cycle; start_rise = start & ~start_q.
- IDLE: start_rise -> SERVE; clear scores/winner; timer<=SERVE_DELAY.
- SERVE: on frame_tick: timer==0 -> PLAY, else timer-1. Without frame_tick timer holds.
- PLAY: miss_left only -> score2+1, serve_dir<=0; miss_right only -> score1+1, serve_dir<=1 (serve toward the player who conceded). Both same cycle -> no score change, serve_dir unchanged, -> POINT. After increment: new score==WIN_SCORE -> GAMEOVER, winner<=1/2; else -> POINT, timer<=POINT_DELAY. State changes one cycle after the miss pulse.
- POINT: counts POINT_DELAY frame ticks (same rule as SERVE), then -> SERVE with timer<=SERVE_DELAY.
- GAMEOVER: holds scores and winner; start_rise -> SERVE with scores/winner cleared, serve_dir<=0, timer<=SERVE_DELAY.
- miss_* ignored in every state except PLAY. start ignored except in IDLE and GAMEOVER.
- A delay of 0 transitions on the next frame_tick. Scores never exceed WIN_SCORE (no wrap).
- frame_tick coincident with a state entry is not counted toward the new state's delay.

Optional Feature:
PONG_PAUSE_EN: defined -> extra input port pause (level, rising-edge detected). A rising edge toggles a paused flag in SERVE, PLAY or POINT. While paused: ball_run=0, ball_rst keeps its state value, timer frozen, miss_* ignored, game_state unchanged. Flag is cleared by reset and on entry to IDLE or GAMEOVER. Undefined -> no pause port; behaviour as above, never paused.

Decomposition:
- Shared package pong_pkg: game_state_e enum (IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4), winner encodings, default SCORE_W/WIN_SCORE, screen-width constants shared with paddle/ball.
- One sub-module: frame_timer, a TIMER_W down-counter with load, load value, tick and done (count==0) signals, used for the SERVE and POINT delays.

Test Plan:
- Reset: rst=0 for 2 cycles mid-PLAY with score1=3 -> next cycle IDLE, scores 0, ball_rst=1, ball_run=0, winner=0.
- Serve timing (SERVE_DELAY=2): start pulse, 3 frame_ticks -> PLAY entered the cycle after the 3rd tick; ball_run=1, ball_rst=0.
- Scoring: in PLAY, miss_right pulse -> score1=1, serve_dir=1, POINT; after POINT_DELAY+1 ticks -> SERVE, then PLAY.
- Simultaneous miss_left and miss_right -> scores unchanged, state POINT, serve_dir unchanged.
- Win (WIN_SCORE=3): three miss_left events -> score2=3, GAMEOVER, winner=2, further misses ignored; start -> SERVE, scores 0, winner 0.
- PONG_PAUSE_EN: pause edge in SERVE with timer=1 -> 5 ticks, no transition, ball_run=0; second pause edge plus 2 ticks -> PLAY.
